dmem_arbiter: RTL
=================

# dmem_arbiter

Two-port round-robin arbiter and access sequencer for the shared data memory. It sits between the core's load/store path (port C) and the debug/program-loader port (port D), and drives the data memory's address, write-data, write-enable and access-control inputs. It holds each granted access for a fixed number of memory-latency cycles, returns read data with a one-cycle acknowledge, and stalls the core while the core's access is pending.

## Interface
- ADDR_WIDTH, 32, address width of both ports and the memory.
- DATA_WIDTH, 32, data width.
- MEM_LATENCY, 1, cycles from access start to valid `mem_rdata_i`; legal range 1..15.
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- c_req_i, d_req_i  in  1  access request per port; held until that port's ack.
- c_we_i, d_we_i  in  1  1 = store, 0 = load.
- c_ctrl_i, d_ctrl_i  in  3  funct3 access size/sign code (000 B, 001 H, 010 W, 100 BU, 101 HU).
- c_addr_i, d_addr_i  in  ADDR_WIDTH  byte address.
- c_wdata_i, d_wdata_i  in  DATA_WIDTH  store data.
- c_ack_o, d_ack_o  out  1  one-cycle completion pulse.
- c_err_o, d_err_o  out  1  valid with ack; misaligned access, no memory operation.
- c_rdata_o, d_rdata_o  out  DATA_WIDTH  load data, valid with ack.
- c_stall_o  out  1  `c_req_i & ~c_ack_o`; freezes the core PC and register writeback.
- mem_en_o  out  1  memory access active.
- mem_we_o  out  1  memory write enable.
- mem_ctrl_o  out  3  funct3 forwarded to the memory.
- mem_addr_o  out  ADDR_WIDTH  memory address.
- mem_wdata_o  out  DATA_WIDTH  memory write data.
- mem_rdata_i  in  DATA_WIDTH  memory read data.

## Operation
- State machine with three states:
  - IDLE: no access in progress.
  - BUSY: a granted access is being held on the memory.
  - ERR: a misaligned request is being rejected.
- IDLE transitions:
  - Sample both requests.
  - If no request is active, stay in IDLE.
  - If only one request is active, grant that port.
  - If both requests are active, grant the port not recorded in `last_grant`.
- On a grant, at the same edge:
  - Latch the granted port's we, ctrl, addr and wdata into an internal request register.
  - Set `last_grant` to the granted port.
  - Load the latency counter with MEM_LATENCY−1.
- Misalignment check, applied to the granted request:
  - A halfword (001/101) access is misaligned if addr[0] is 1.
  - A word (010) access is misaligned if addr[1:0] is nonzero.
  - A misaligned request goes to ERR instead of BUSY.
  - Unlisted ctrl codes are treated as word accesses.
- BUSY:
  - `mem_en_o`=1; `mem_addr_o`, `mem_ctrl_o` and `mem_wdata_o` come from the request register.
  - `mem_we_o` is asserted only in the first BUSY cycle, so each store writes exactly once.
  - The counter decrements each cycle.
  - When the counter is 0: assert the granted port's `ack_o`, drive its `rdata_o` = `mem_rdata_i` (all zeros for stores), then return to IDLE.
- ERR: `ack_o`=1 and `err_o`=1 to the granted port for one cycle; `rdata_o`=0; memory outputs stay idle; then return to IDLE.
- Port outputs:
  - The non-granted port sees ack=0, err=0, rdata=0.
  - The memory outputs are all zero whenever the state is not BUSY.
- Reset:
  - State returns to IDLE, `last_grant` is set to D (so C wins the first tie), and the counter is cleared.
  - An access in flight is abandoned with no ack. A store already issued is not undone.

## Timing
- Every output is 0 during and after reset until the first grant.
- Load or store, request seen in IDLE at cycle T:
  - BUSY covers cycles T+1 .. T+MEM_LATENCY.
  - ack occurs at T+MEM_LATENCY.
  - IDLE resumes at T+MEM_LATENCY+1.
- Throughput: one access per MEM_LATENCY+1 cycles.
- Misaligned access: ERR at T+1, with ack and err at T+1.
- Request handling around ack:
  - A request still high in the cycle after its ack is a new request.
  - Requests changing while not granted are don't-care.
  - Requests are not re-sampled during BUSY or ERR.
- With both ports continuously requesting, grants alternate strictly C, D, C, D, …
- `c_stall_o` is combinational: high from request assertion through the cycle before ack, low in the ack cycle.

## Test plan
- Reset, then C loads word 0x100 with MEM_LATENCY=2 and memory returning 0xDEADBEEF → `mem_en_o` high in T+1..T+2, `c_ack_o` pulse at T+2 with `c_rdata_o`=0xDEADBEEF, `c_stall_o` high at T and T+1.
- D stores 0x000000AA with ctrl 000 to address 0x23 → `mem_we_o` high for exactly one cycle, `mem_ctrl_o`=000, `mem_addr_o`=0x23, `d_ack_o` pulse with `d_err_o`=0.
- Both ports request from reset and hold → grant order C, D, C, D over four accesses, each ack exactly MEM_LATENCY cycles after its grant.
- C requests a word at 0x102 → `c_ack_o`=1 and `c_err_o`=1 at T+1, `mem_en_o` never asserted, `c_rdata_o`=0.
- `rst_i` pulsed in the middle of BUSY for a D load → no `d_ack_o`, all outputs 0 next cycle, and the first tie afterwards is granted to C.
- MEM_LATENCY=15 back-to-back C loads → acks spaced exactly 16 cycles apart, `c_stall_o` low only in the ack cycles.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter between core (C) and debug (D) ports for the data memory.
// Holds each granted access for MEM_LATENCY cycles; misaligned requests are rejected.
module dmem_arbiter #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int MEM_LATENCY = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  c_req_i,
  input  logic                  d_req_i,
  input  logic                  c_we_i,
  input  logic                  d_we_i,
  input  logic [2:0]            c_ctrl_i,
  input  logic [2:0]            d_ctrl_i,
  input  logic [ADDR_WIDTH-1:0] c_addr_i,
  input  logic [ADDR_WIDTH-1:0] d_addr_i,
  input  logic [DATA_WIDTH-1:0] c_wdata_i,
  input  logic [DATA_WIDTH-1:0] d_wdata_i,
  output logic                  c_ack_o,
  output logic                  d_ack_o,
  output logic                  c_err_o,
  output logic                  d_err_o,
  output logic [DATA_WIDTH-1:0] c_rdata_o,
  output logic [DATA_WIDTH-1:0] d_rdata_o,
  output logic                  c_stall_o,
  output logic                  mem_en_o,
  output logic                  mem_we_o,
  output logic [2:0]            mem_ctrl_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i
);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    ERR
  } state_e;

  localparam logic [3:0] LAT_M1 = 4'(MEM_LATENCY - 1);

  state_e                state_q, state_d;
  logic                  last_q, last_d;
  logic                  gnt_q, gnt_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  we_q, we_d;
  logic [2:0]            ctrl_q, ctrl_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;

  logic                  sel;
  logic                  s_we;
  logic [2:0]            s_ctrl;
  logic [ADDR_WIDTH-1:0] s_addr;
  logic [DATA_WIDTH-1:0] s_wdata;
  logic                  mis;
  logic                  ack;
  logic                  err;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  en;
  logic                  wen;

  // sel = 1 picks D; on a tie the port not granted last time wins
  assign sel     = (c_req_i & d_req_i) ? ~last_q : d_req_i;
  assign s_we    = sel ? d_we_i    : c_we_i;
  assign s_ctrl  = sel ? d_ctrl_i  : c_ctrl_i;
  assign s_addr  = sel ? d_addr_i  : c_addr_i;
  assign s_wdata = sel ? d_wdata_i : c_wdata_i;

  always_comb begin
    mis = 1'b0;
    unique case (1'b1)
      s_ctrl[1:0] == 2'b00: mis = 1'b0;
      s_ctrl[1:0] == 2'b01: mis = s_addr[0];
      default:              mis = |s_addr[1:0];
    endcase
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    gnt_d   = gnt_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    ctrl_d  = ctrl_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    ack     = 1'b0;
    err     = 1'b0;
    rdata   = '0;
    en      = 1'b0;
    wen     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (c_req_i | d_req_i) begin
          gnt_d   = sel;
          last_d  = sel;
          we_d    = s_we;
          ctrl_d  = s_ctrl;
          addr_d  = s_addr;
          wdata_d = s_wdata;
          cnt_d   = LAT_M1;
          state_d = mis ? ERR : BUSY;
        end
      end
      BUSY: begin
        en  = 1'b1;
        wen = we_q & (cnt_q == LAT_M1);
        if (cnt_q == 4'd0) begin
          ack     = 1'b1;
          rdata   = we_q ? '0 : mem_rdata_i;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ERR: begin
        ack     = 1'b1;
        err     = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      gnt_q   <= 1'b0;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      ctrl_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      gnt_q   <= gnt_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      ctrl_q  <= ctrl_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  // everything is forced low while reset is held
  assign c_ack_o     = ~rst_i & ack & ~gnt_q;
  assign d_ack_o     = ~rst_i & ack &  gnt_q;
  assign c_err_o     = ~rst_i & err & ~gnt_q;
  assign d_err_o     = ~rst_i & err &  gnt_q;
  assign c_rdata_o   = (~rst_i & ~gnt_q) ? rdata : '0;
  assign d_rdata_o   = (~rst_i &  gnt_q) ? rdata : '0;
  assign c_stall_o   = ~rst_i & c_req_i & ~c_ack_o;
  assign mem_en_o    = ~rst_i & en;
  assign mem_we_o    = ~rst_i & wen;
  assign mem_ctrl_o  = (~rst_i & en) ? ctrl_q  : '0;
  assign mem_addr_o  = (~rst_i & en) ? addr_q  : '0;
  assign mem_wdata_o = (~rst_i & en) ? wdata_q : '0;

endmodule
